// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order reads on the instruction bus,
// and buffers up to two returned words for the if_id register, with stall and redirect.
module ifu_fetch #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [DATA_W-1:0] INS_NOP    = DATA_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_flag_i,
    output logic              ibus_req_o,
    output logic [ADDR_W-1:0] ibus_addr_o,
    input  logic              ibus_gnt_i,
    input  logic              ibus_rvalid_i,
    input  logic [DATA_W-1:0] ibus_rdata_i,
    output logic [DATA_W-1:0] ins_o,
    output logic [ADDR_W-1:0] ins_addr_o,
    output logic              ins_valid_o
);

    localparam int unsigned DEPTH = 2;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        outst_q, outst_d;
    logic [1:0]        count_q, count_d;
    logic [1:0]        disc_q, disc_d;

    logic [ADDR_W-1:0] aq_q [DEPTH];
    logic              aq_rd_q, aq_wr_q;

    logic [DATA_W-1:0] dq_data_q [DEPTH];
    logic [ADDR_W-1:0] dq_addr_q [DEPTH];
    logic              dq_rd_q, dq_wr_q;

    logic              rvalid_c;
    logic              pop_c;
    logic              push_c;
    logic              hs_c;
    logic [2:0]        credit_c;
    logic [ADDR_W-1:0] jump_tgt_c;

    // Responses with nothing outstanding are ignored outright.
    assign rvalid_c   = ibus_rvalid_i & (outst_q != 2'd0);
    assign jump_tgt_c = jump_addr_i & ~ADDR_W'(3);

    // Head of the data queue drives the if_id inputs directly.
    assign ins_valid_o = (count_q != 2'd0);
    assign ins_o       = ins_valid_o ? dq_data_q[dq_rd_q] : INS_NOP;
    assign ins_addr_o  = ins_valid_o ? dq_addr_q[dq_rd_q] : RESET_ADDR;

    assign pop_c  = ins_valid_o & ~hold_flag_i & ~jump_flag_i;
    assign push_c = rvalid_c & (disc_q == 2'd0) & ~jump_flag_i;

    // Credit counts in-flight requests plus buffered words, freeing the slot popped now.
    assign credit_c    = 3'(outst_q) + 3'(count_q) - 3'(pop_c);
    assign ibus_req_o  = ~rst & ~jump_flag_i & (credit_c < 3'd2);
    assign ibus_addr_o = pc_q;
    assign hs_c        = ibus_req_o & ibus_gnt_i;

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        disc_d  = disc_q;
        outst_d = outst_q + 2'(hs_c) - 2'(rvalid_c);
        if (jump_flag_i) begin
            // Everything already requested belongs to the old stream and must be dropped.
            pc_d    = jump_tgt_c;
            count_d = 2'd0;
            disc_d  = outst_q - 2'(rvalid_c);
        end else begin
            if (hs_c) begin
                pc_d = pc_q + ADDR_W'(4);
            end
            count_d = count_q + 2'(push_c) - 2'(pop_c);
            if (rvalid_c && (disc_q != 2'd0)) begin
                disc_d = disc_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_ADDR;
            outst_q <= 2'd0;
            count_q <= 2'd0;
            disc_q  <= 2'd0;
            aq_rd_q <= 1'b0;
            aq_wr_q <= 1'b0;
            dq_rd_q <= 1'b0;
            dq_wr_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            count_q <= count_d;
            disc_q  <= disc_d;
            if (hs_c) begin
                aq_wr_q <= ~aq_wr_q;
            end
            if (rvalid_c) begin
                aq_rd_q <= ~aq_rd_q;
            end
            if (jump_flag_i) begin
                dq_rd_q <= 1'b0;
                dq_wr_q <= 1'b0;
            end else begin
                if (push_c) begin
                    dq_wr_q <= ~dq_wr_q;
                end
                if (pop_c) begin
                    dq_rd_q <= ~dq_rd_q;
                end
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (hs_c) begin
            aq_q[aq_wr_q] <= pc_q;
        end
        if (push_c) begin
            dq_data_q[dq_wr_q] <= ibus_rdata_i;
            dq_addr_q[dq_wr_q] <= aq_q[aq_rd_q];
        end
    end

endmodule
